// File: rtl/spi_frame_pkg.sv
// Shared widths and FSM encoding for the SPI frame master.
// Frame layout is {addr, data}, shifted MSB first.
package spi_frame_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    TRAIL,
    GAP
  } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counter that times one phase of the frame FSM.
// Loading arms it; expire pulses once when the count reaches zero.
module spi_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end else begin
      armed <= 1'b0;
    end
  end

  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI master that sends one {addr, data} frame per request
// and returns the word shifted in from miso.
module spi_frame_master #(
  parameter int ADDR_W  = spi_frame_pkg::ADDR_W,
  parameter int DATA_W  = spi_frame_pkg::DATA_W,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              spi_clk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs,
  output logic              busy
);

  localparam int FW   = ADDR_W + DATA_W;
  localparam int TMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(FW + 1);

  localparam logic [TW-1:0] PH_LD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(CS_GAP - 1);
  localparam logic [BW-1:0] LAST   = BW'(FW - 1);

  import spi_frame_pkg::*;

  state_t        state;
  logic [FW-1:0] tx;
  logic [FW-1:0] rx;
  logic [BW-1:0] bit_cnt;
  logic          load;
  logic          expire;
  logic [TW-1:0] load_val;
  logic          timed;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // GAP is the only phase that reloads with a different length
  assign timed    = (state == LOW) || (state == HIGH) ||
                    (state == TRAIL);
  assign load     = (req_ready && req_valid) ||
                    (timed && expire);
  assign load_val = (state == TRAIL) ? GAP_LD : PH_LD;

  spi_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      cs        <= 1'b0;
      spi_clk   <= 1'b0;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            tx      <= {req_addr, req_data};
            rx      <= '0;
            bit_cnt <= '0;
            cs      <= 1'b1;
            mosi    <= req_addr[ADDR_W-1];
            state   <= LOW;
          end
        end
        LOW: begin
          if (expire) begin
            spi_clk <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (expire) begin
            spi_clk <= 1'b0;
            rx      <= {rx[FW-2:0], miso};
            if (bit_cnt == LAST) begin
              state <= TRAIL;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= tx << 1;
              mosi    <= tx[FW-2];
              state   <= LOW;
            end
          end
        end
        TRAIL: begin
          if (expire) begin
            cs        <= 1'b0;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_addr  <= rx[FW-1 -: ADDR_W];
            rsp_data  <= rx[DATA_W-1:0];
            state     <= GAP;
          end
        end
        GAP: begin
          if (expire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench: a slave model drives miso from a chosen word,
// monitors decode the bus and check responses against queues.
module tb_spi_frame_master;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int FW = AW + DW;
  localparam int CD = 4;
  localparam int CG = 8;

  logic          sys_clk   = 1'b0;
  logic          sys_rst   = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_data  = '0;
  logic          miso      = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          spi_clk;
  logic          mosi;
  logic          cs;
  logic          busy;

  typedef struct {
    logic [FW-1:0] tx;
    logic [FW-1:0] rx;
    bit            abort;
    bit            b2b;
  } frm_t;

  frm_t          frm_q[$];
  logic [FW-1:0] rsp_q[$];

  int n_cmp    = 0;
  int n_bad    = 0;
  int rises    = 0;
  int stab_err = 0;
  int busy_acc = 0;

  always #5 sys_clk = ~sys_clk;

  spi_frame_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .CLK_DIV (CD),
    .CS_GAP  (CG)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .spi_clk   (spi_clk),
    .mosi      (mosi),
    .miso      (miso),
    .cs        (cs),
    .busy      (busy)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bus monitor + miso slave model + frame timing checks
  logic          pcs = 0, psclk = 0, pmosi = 0, prv = 0;
  int            cs_cnt = 0, low_cnt = 0, bidx = 0, mosi_err = 0;
  bit            done_prev = 0;
  logic [FW-1:0] mw = '0, cur_rx = '0, last_rsp = '0, e;
  frm_t          cf;

  always @(negedge sys_clk) begin
    if (cs && !pcs) begin
      if (frm_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame: cs rose with no request");
        cf.rx = '0; cf.b2b = 0;
      end else begin
        cf = frm_q[0];
      end
      if (cf.b2b) begin
        check("cs_gap_b2b", 64'(low_cnt), 64'(CG + 1));
      end else if (done_prev) begin
        n_cmp++;
        if (low_cnt < CG + 1) begin
          n_bad++;
          $display("FAIL cs_gap_min: got %0d need >= %0d",
                   low_cnt, CG + 1);
        end
      end
      cs_cnt = 0; rises = 0; bidx = 0; mosi_err = 0; mw = '0;
      cur_rx = cf.rx;
      miso = cur_rx[FW-1];
    end
    if (cs) begin
      cs_cnt++;
      if (spi_clk && !psclk) begin
        rises++;
        mw = {mw[FW-2:0], mosi};
      end
      if (spi_clk && psclk && (mosi !== pmosi)) mosi_err++;
      if (!spi_clk && psclk) begin
        bidx++;
        if (bidx < FW) miso = cur_rx[FW-1-bidx];
      end
    end
    if (!cs && pcs) begin
      if (frm_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_queue: cs fell with no request");
      end else begin
        cf = frm_q.pop_front();
        if (!cf.abort) begin
          check("cs_high_cycles", 64'(cs_cnt), 64'((2*FW+1)*CD));
          check("spi_clk_rises", 64'(rises), 64'(FW));
          check("mosi_addr", 64'(mw[FW-1:DW]), 64'(cf.tx[FW-1:DW]));
          check("mosi_data", 64'(mw[DW-1:0]), 64'(cf.tx[DW-1:0]));
          check("mosi_stable_high", 64'(mosi_err), 64'(0));
          check("rsp_at_cs_fall", 64'(rsp_valid), 64'(1));
        end
        done_prev = !cf.abort;
      end
      low_cnt = 0;
      miso = 1'b0;
    end
    if (!cs) low_cnt++;
    if (req_ready && busy) busy_acc++;
    if (rsp_valid) begin
      if (prv) stab_err++;
      if (rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: addr %0h data %0h",
                 rsp_addr, rsp_data);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_addr", 64'(rsp_addr), 64'(e[FW-1:DW]));
        check("rsp_data", 64'(rsp_data), 64'(e[DW-1:0]));
      end
      last_rsp = {rsp_addr, rsp_data};
    end else if (sys_rst) begin
      last_rsp = {rsp_addr, rsp_data};
    end else if ({rsp_addr, rsp_data} !== last_rsp) begin
      stab_err++;
    end
    pcs = cs; psclk = spi_clk; pmosi = mosi; prv = rsp_valid;
  end

  task automatic send(input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input logic [FW-1:0] rx,
                      input bit hold,
                      input bit b2b,
                      input bit abort);
    int   n;
    frm_t f;
    n = 0;
    @(negedge sys_clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready %0b required 1",
               req_ready);
      req_valid = 1'b0;
      return;
    end
    f.tx = {a, d}; f.rx = rx; f.abort = abort; f.b2b = b2b;
    frm_q.push_back(f);
    if (!abort) rsp_q.push_back(rx);
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (!hold) req_valid = 1'b0;
    req_addr = AW'($urandom);
    req_data = DW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || frm_q.size() != 0 || busy)
           && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding",
               rsp_q.size());
    end
  endtask

  task automatic abort_frame();
    int n;
    send(AW'($urandom), DW'($urandom), FW'($urandom), 0, 0, 1);
    n = 0;
    while (!cs && n < 100) begin @(negedge sys_clk); n++; end
    @(negedge sys_clk);
    while (rises < 10 && n < 1000) begin @(negedge sys_clk); n++; end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL abort_wait: rises %0d required 10", rises);
    end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("abort_cs", 64'(cs), 64'(0));
    check("abort_spi_clk", 64'(spi_clk), 64'(0));
    check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] prev_tx;
    logic [FW-1:0] rx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            mode;

    repeat (3) @(negedge sys_clk);
    check("rst_cs", 64'(cs), 64'(0));
    check("rst_spi_clk", 64'(spi_clk), 64'(0));
    check("rst_mosi", 64'(mosi), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // register-slave loopback: second frame reads back the first
    send(6'h01, 16'hAAAA, FW'($urandom), 0, 0, 0);
    send(6'h01, 16'h0000, {6'h01, 16'hAAAA}, 0, 0, 0);
    send(6'h05, 16'h5555, '1, 0, 0, 0);
    send(AW'($urandom), DW'($urandom), '0, 0, 0, 0);
    drain();

    // held request: three back-to-back frames
    send(AW'($urandom), DW'($urandom), FW'($urandom), 1, 0, 0);
    send(AW'($urandom), DW'($urandom), FW'($urandom), 1, 1, 0);
    send(AW'($urandom), DW'($urandom), FW'($urandom), 0, 1, 0);
    drain();

    abort_frame();
    send(6'h07, 16'h0000, FW'($urandom), 0, 0, 0);
    drain();

    prev_tx = '0;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge sys_clk);
      a    = AW'($urandom);
      d    = DW'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0)      rx = '1;
      else if (mode == 1) rx = '0;
      else if (mode == 2) rx = prev_tx;
      else                rx = FW'($urandom);
      send(a, d, rx, 0, 0, 0);
      prev_tx = {a, d};
    end
    drain();

    check("accept_while_busy", 64'(busy_acc), 64'(0));
    check("rsp_stable_pulse", 64'(stab_err), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
